instr_encoder_loader: RTL and testbench

//  Inverse of the instruction decoder: takes mnemonic-level instructions (op code + fields), encodes

---
 rtl/instr_pkg.sv | 65 ++++++
 rtl/sync_fifo.sv | 55 +++++
 rtl/instr_encoder_loader.sv | 203 ++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Mnemonic, opcode, funct and field-position constants shared by the MIPS encoder/loader and decoder.
package instr_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_NOR  = 5'd5;
    localparam logic [4:0] OP_SLT  = 5'd6;
    localparam logic [4:0] OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8;
    localparam logic [4:0] OP_JR   = 5'd9;
    localparam logic [4:0] OP_JALR = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_SLTI = 5'd13;
    localparam logic [4:0] OP_BEQ  = 5'd14;
    localparam logic [4:0] OP_BNE  = 5'd15;
    localparam logic [4:0] OP_LW   = 5'd16;
    localparam logic [4:0] OP_LH   = 5'd17;
    localparam logic [4:0] OP_SW   = 5'd18;
    localparam logic [4:0] OP_SH   = 5'd19;
    localparam logic [4:0] OP_J    = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_LH    = 6'h21;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_SH    = 6'h29;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} ld_state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes mnemonic-level instructions to MIPS words and streams them into instruction memory via a FIFO.
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          IM_WORDS  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_end,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        im_wen,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    input  logic        im_busy,
    output logic        load_done,
    output logic        err_op,
    output logic        err_ovf,
    output logic [15:0] wr_count
);

    function automatic enc_t encode(input logic [4:0] f_op, f_rs, f_rt, f_rd, f_sh,
                                    input logic [15:0] f_imm, input logic [25:0] f_tgt);
        enc_t       e;
        logic [5:0] opc, fn;
        logic [4:0] rs_v, rt_v, rd_v, sh_v;
        logic       rtype, jtype;
        e = '0; opc = '0; fn = '0; rtype = 1'b0; jtype = 1'b0;
        rs_v = f_rs; rt_v = f_rt; rd_v = f_rd; sh_v = f_sh;
        e.legal = 1'b1;
        case (f_op)
            OP_ADD:  begin rtype = 1'b1; fn = FN_ADD;  end
            OP_SUB:  begin rtype = 1'b1; fn = FN_SUB;  end
            OP_AND:  begin rtype = 1'b1; fn = FN_AND;  end
            OP_OR:   begin rtype = 1'b1; fn = FN_OR;   end
            OP_XOR:  begin rtype = 1'b1; fn = FN_XOR;  end
            OP_NOR:  begin rtype = 1'b1; fn = FN_NOR;  end
            OP_SLT:  begin rtype = 1'b1; fn = FN_SLT;  end
            OP_SLL:  begin rtype = 1'b1; fn = FN_SLL;  rs_v = '0; end
            OP_SRL:  begin rtype = 1'b1; fn = FN_SRL;  rs_v = '0; end
            OP_JR:   begin rtype = 1'b1; fn = FN_JR;   rt_v = '0; rd_v = '0; sh_v = '0; end
            OP_JALR: begin rtype = 1'b1; fn = FN_JALR; end
            OP_ADDI: opc = OPC_ADDI;
            OP_ANDI: opc = OPC_ANDI;
            OP_SLTI: opc = OPC_SLTI;
            OP_BEQ:  opc = OPC_BEQ;
            OP_BNE:  opc = OPC_BNE;
            OP_LW:   opc = OPC_LW;
            OP_LH:   opc = OPC_LH;
            OP_SW:   opc = OPC_SW;
            OP_SH:   opc = OPC_SH;
            OP_J:    begin jtype = 1'b1; opc = OPC_J;   end
            OP_JAL:  begin jtype = 1'b1; opc = OPC_JAL; end
            default: e.legal = 1'b0;
        endcase
        if (e.legal) begin
            if (rtype) begin
                e.word[OPC_LSB +: 6]   = OPC_RTYPE;
                e.word[RS_LSB +: 5]    = rs_v;
                e.word[RT_LSB +: 5]    = rt_v;
                e.word[RD_LSB +: 5]    = rd_v;
                e.word[SHAMT_LSB +: 5] = sh_v;
                e.word[5:0]            = fn;
            end else if (jtype) begin
                e.word[OPC_LSB +: 6] = opc;
                e.word[25:0]         = f_tgt;
            end else begin
                e.word[OPC_LSB +: 6] = opc;
                e.word[RS_LSB +: 5]  = rs_v;
                e.word[RT_LSB +: 5]  = rt_v;
                e.word[15:0]         = f_imm;
            end
        end
        return e;
    endfunction

    ld_state_e   state_q, state_d;
    logic        end_pend_q, end_pend_d;
    logic        im_wen_q, im_wen_d;
    logic [31:0] im_addr_q, im_addr_d;
    logic [31:0] im_wdata_q, im_wdata_d;
    logic        load_done_q, load_done_d;
    logic        err_op_q, err_op_d;
    logic        err_ovf_q, err_ovf_d;
    logic [15:0] wr_count_q, wr_count_d;

    enc_t        enc;
    logic        xfer, push, pop, wr_done, ovf_hit;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_head;
    logic [15:0] cnt_eff;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (enc.word),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign enc      = encode(op, rs, rt, rd, shamt, imm, target);
    assign in_ready = (state_q == ST_LOAD) && !fifo_full;
    assign xfer     = in_valid && in_ready;
    assign push     = xfer && enc.legal;
    assign wr_done  = im_wen_q && !im_busy;
    assign pop      = (!im_wen_q || !im_busy) && !fifo_empty;
    // Count including a write completing this cycle, so the limit check sees it.
    assign cnt_eff  = wr_count_q + {15'd0, wr_done};
    assign ovf_hit  = pop && (cnt_eff >= 16'(IM_WORDS));

    always_comb begin
        state_d     = state_q;
        end_pend_d  = end_pend_q;
        im_wen_d    = im_wen_q;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        load_done_d = 1'b0;
        err_op_d    = err_op_q;
        err_ovf_d   = err_ovf_q;
        wr_count_d  = wr_count_q;

        if (wr_done) begin
            im_wen_d   = 1'b0;
            im_addr_d  = im_addr_q + 32'd4;
            wr_count_d = cnt_eff;
        end
        if (pop) begin
            if (ovf_hit) begin
                err_ovf_d = 1'b1;
            end else begin
                im_wen_d   = 1'b1;
                im_wdata_d = fifo_head;
            end
        end
        if (xfer && !enc.legal) err_op_d = 1'b1;

        case (state_q)
            ST_IDLE: if (load_start) begin
                state_d    = ST_LOAD;
                end_pend_d = load_end;
                im_addr_d  = BASE_ADDR;
                wr_count_d = '0;
                err_op_d   = 1'b0;
                err_ovf_d  = 1'b0;
            end
            ST_LOAD: if (load_end || end_pend_q) begin
                state_d    = ST_DRAIN;
                end_pend_d = 1'b0;
            end
            ST_DRAIN: if (fifo_empty && !im_wen_q) begin
                state_d     = ST_DONE;
                load_done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            end_pend_q  <= 1'b0;
            im_wen_q    <= 1'b0;
            im_addr_q   <= BASE_ADDR;
            im_wdata_q  <= '0;
            load_done_q <= 1'b0;
            err_op_q    <= 1'b0;
            err_ovf_q   <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            end_pend_q  <= end_pend_d;
            im_wen_q    <= im_wen_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            load_done_q <= load_done_d;
            err_op_q    <= err_op_d;
            err_ovf_q   <= err_ovf_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign im_wen    = im_wen_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign load_done = load_done_q;
    assign err_op    = err_op_q;
    assign err_ovf   = err_ovf_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: vector table, directed multi-cycle sequences and a random stream.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0, load_end = 1'b0, in_valid = 1'b0, im_busy = 1'b0;
    logic [4:0]  op = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;

    logic        in_ready, im_wen, load_done, err_op, err_ovf;
    logic [31:0] im_addr, im_wdata;
    logic [15:0] wr_count;
    logic        o_in_ready, o_im_wen, o_load_done, o_err_op, o_err_ovf;
    logic [31:0] o_im_addr, o_im_wdata;
    logic [15:0] o_wr_count;

    always #5 clk = ~clk;

    instr_encoder_loader u_dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .imm(imm), .target(target), .im_wen(im_wen), .im_addr(im_addr),
        .im_wdata(im_wdata), .im_busy(im_busy), .load_done(load_done), .err_op(err_op),
        .err_ovf(err_ovf), .wr_count(wr_count)
    );

    // Second instance with a tiny memory to exercise the overflow limit on the same stimulus.
    instr_encoder_loader #(.IM_WORDS(4)) u_ovf (
        .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
        .in_valid(in_valid), .in_ready(o_in_ready), .op(op), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .imm(imm), .target(target), .im_wen(o_im_wen), .im_addr(o_im_addr),
        .im_wdata(o_im_wdata), .im_busy(im_busy), .load_done(o_load_done), .err_op(o_err_op),
        .err_ovf(o_err_ovf), .wr_count(o_wr_count)
    );

    int errors = 0;
    int checks = 0;

    // Monitor-owned records of completed memory writes
    bit [31:0] got_data[$];
    bit [31:0] got_addr[$];
    int        got_cyc[$];
    int        cyc = 0, done_cnt = 0, ovf_wr = 0, ovf_done = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (im_wen && !im_busy) begin
                got_data.push_back(im_wdata);
                got_addr.push_back(im_addr);
                got_cyc.push_back(cyc);
            end
            if (load_done) done_cnt++;
            if (o_im_wen && !im_busy) ovf_wr++;
            if (o_load_done) ovf_done++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference encoder: mnemonic index -> format class and MIPS code, then field arithmetic.
    int unsigned fmt_tab [22] = '{0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1,1, 2,2};
    int unsigned code_tab[22] = '{'h20,'h22,'h24,'h25,'h26,'h27,'h2A,'h00,'h02,'h08,'h09,
                                  'h08,'h0C,'h0A,'h04,'h05,'h23,'h21,'h2B,'h29, 'h02,'h03};

    function automatic bit [32:0] ref_enc(input int unsigned o, r_s, r_t, r_d, sh, im, tg);
        int unsigned w, s, t, d, a;
        if (o > 21) return 33'd0;
        s = r_s; t = r_t; d = r_d; a = sh;
        if (o == 7 || o == 8) s = 0;
        if (o == 9) begin t = 0; d = 0; a = 0; end
        case (fmt_tab[o])
            0: w = s * (2**21) + t * (2**16) + d * (2**11) + a * 64 + code_tab[o];
            1: w = code_tab[o] * (2**26) + s * (2**21) + t * (2**16) + im;
            default: w = code_tab[o] * (2**26) + tg;
        endcase
        return {1'b1, w};
    endfunction

    bit [31:0] exp_q[$];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [4:0] op_i, rs_i, rt_i, rd_i, sh_i,
                        input logic [15:0] imm_i, input logic [25:0] tgt_i);
        bit acc = 0;
        bit [32:0] m;
        op = op_i; rs = rs_i; rt = rt_i; rd = rd_i; shamt = sh_i; imm = imm_i; target = tgt_i;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        m = ref_enc(op_i, rs_i, rt_i, rd_i, sh_i, imm_i, tgt_i);
        if (m[32]) exp_q.push_back(m[31:0]);
    endtask

    task automatic start_session();
        exp_q.delete();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic end_and_wait(input string name);
        bit seen = 0;
        int d0 = done_cnt;
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = load_done;
        end
        tick(); tick(); tick();
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic cmp_writes(input string name, input int base);
        chk({name, "_nwrites"}, got_data.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), got_data[base + i], exp_q[i]);
            chk($sformatf("%s_addr%0d", name, i), got_addr[base + i], 32'(4 * i));
        end
    endtask

    typedef struct {
        logic [4:0]  op, rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] word;
    } vec_t;
    vec_t vt[9];

    initial begin
        int base, nlegal, nr, hold_bad, ok;
        bit any_ill, stim_done;
        logic [31:0] snap_a, snap_d;

        vt[0] = '{5'd11, 5'd0,  5'd2,  5'd0,  5'd0, 16'h0005, 26'h0,       32'h20020005}; // addi
        vt[1] = '{5'd16, 5'd1,  5'd4,  5'd0,  5'd0, 16'h0008, 26'h0,       32'h8C240008}; // lw
        vt[2] = '{5'd20, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h100,     32'h08000100}; // j
        vt[3] = '{5'd7,  5'd7,  5'd1,  5'd2,  5'd4, 16'h0,    26'h0,       32'h00011100}; // sll
        vt[4] = '{5'd31, 5'd1,  5'd1,  5'd1,  5'd1, 16'h1,    26'h1,       32'h0};        // illegal
        vt[5] = '{5'd9,  5'd31, 5'd5,  5'd6,  5'd3, 16'h0,    26'h0,       32'h03E00008}; // jr
        vt[6] = '{5'd21, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h3FFFFFF, 32'h0FFFFFFF}; // jal
        vt[7] = '{5'd14, 5'd3,  5'd4,  5'd0,  5'd0, 16'hFFFE, 26'h0,       32'h1064FFFE}; // beq
        vt[8] = '{5'd5,  5'd5,  5'd6,  5'd7,  5'd0, 16'h0,    26'h0,       32'h00A63827}; // nor

        repeat (3) tick();
        chk("rst_im_wen", im_wen, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_im_wdata", im_wdata, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_err_op", err_op, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_wr_count", wr_count, 0);
        rst = 1'b0;
        tick();

        // add after load_start: write two cycles after acceptance
        start_session();
        chk("t1_in_ready_load", in_ready, 1);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("t1_wen_early", im_wen, 0);
        tick();
        chk("t1_wen", im_wen, 1);
        chk("t1_addr", im_addr, 32'h0);
        chk("t1_wdata", im_wdata, 32'h00221820);
        tick();
        chk("t1_wr_count", wr_count, 1);
        end_and_wait("t1");
        chk("t1_in_ready_idle", in_ready, 0);

        // vector table, back-to-back, including an illegal op
        base = got_data.size();
        start_session();
        nlegal = 0;
        for (int i = 0; i < 9; i++) begin
            send(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].imm, vt[i].tgt);
            if (i == 4) chk("tab_err_op_set", err_op, 1);
        end
        end_and_wait("tab");
        chk("tab_nwrites", got_data.size() - base, 8);
        for (int i = 0, j = 0; i < 9; i++) begin
            if (i == 4) continue;
            if (base + j < got_data.size()) begin
                chk($sformatf("tab_word%0d", i), got_data[base + j], vt[i].word);
                chk($sformatf("tab_addr%0d", i), got_addr[base + j], 32'(4 * j));
            end
            j++;
        end
        if (got_data.size() >= base + 3) begin
            chk("tab_consec1", got_cyc[base + 1] - got_cyc[base], 1);
            chk("tab_consec2", got_cyc[base + 2] - got_cyc[base + 1], 1);
        end
        chk("tab_err_op", err_op, 1);
        chk("tab_wr_count", wr_count, 8);

        // stall while streaming 6 words
        base = got_data.size();
        start_session();
        nr = 0; hold_bad = 0; ok = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(5'd1, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0, 26'h0);
            end
            begin
                for (int k = 0; k < 50 && !ok; k++) begin
                    @(negedge clk);
                    ok = im_wen;
                end
                tick();
                im_busy = 1'b1;
                @(negedge clk);
                snap_a = im_addr; snap_d = im_wdata;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!im_wen || im_addr != snap_a || im_wdata != snap_d) hold_bad++;
                    if (!in_ready) nr++;
                end
                tick();
                im_busy = 1'b0;
            end
        join
        chk("stall_saw_wen", ok, 1);
        chk("stall_hold", hold_bad, 0);
        chk("stall_not_ready", (nr > 0), 1);
        end_and_wait("stall");
        cmp_writes("stall", base);

        // 5 words into the 4-word memory instance
        base = ovf_wr;
        nr = ovf_done;
        start_session();
        for (int i = 0; i < 5; i++) send(5'd11, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 26'h0);
        end_and_wait("ovf");
        chk("ovf_writes", ovf_wr - base, 4);
        chk("ovf_err", o_err_ovf, 1);
        chk("ovf_wr_count", o_wr_count, 4);
        chk("ovf_done_once", ovf_done - nr, 1);
        chk("big_err_ovf", err_ovf, 0);
        chk("big_wr_count", wr_count, 5);

        // load_start and load_end together: empty session
        base = got_data.size();
        load_start = 1'b1; load_end = 1'b1;
        tick();
        load_start = 1'b0; load_end = 1'b0;
        nr = done_cnt;
        repeat (8) tick();
        chk("empty_done", done_cnt - nr, 1);
        chk("empty_writes", got_data.size() - base, 0);
        chk("empty_wr_count", wr_count, 0);
        chk("empty_err_ovf", err_ovf, 0);

        // random stream with random stalls
        base = got_data.size();
        start_session();
        nlegal = 0; any_ill = 0; stim_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [4:0] ro;
                    ro = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 21));
                    if (ro > 21) any_ill = 1; else nlegal++;
                    send(ro, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                         16'($urandom), 26'($urandom));
                    repeat ($urandom_range(0, 2)) tick();
                end
                stim_done = 1;
            end
            begin
                for (int k = 0; k < 2000 && !stim_done; k++) begin
                    tick();
                    im_busy = ($urandom_range(0, 2) == 0);
                end
                im_busy = 1'b0;
            end
        join
        end_and_wait("rnd");
        cmp_writes("rnd", base);
        chk("rnd_wr_count", wr_count, 16'(nlegal));
        chk("rnd_err_op", err_op, 32'(any_ill));

        // reset with words queued behind a stalled write
        start_session();
        im_busy = 1'b1;
        for (int i = 0; i < 3; i++) send(5'd3, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0, 26'h0);
        chk("rst6_wen_before", im_wen, 1);
        base = got_data.size();
        nr = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst6_wen", im_wen, 0);
        chk("rst6_in_ready", in_ready, 0);
        chk("rst6_addr", im_addr, 0);
        im_busy = 1'b0;
        repeat (6) tick();
        chk("rst6_no_writes", got_data.size() - base, 0);
        chk("rst6_wen_after", im_wen, 0);
        chk("rst6_wr_count", wr_count, 0);
        chk("rst6_no_done", done_cnt - nr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
